jtag_dbg_bridge: RTL



---
 rtl/jtag_dbg_pkg.sv | 33 +++
 rtl/dbg_timeout_ctr.sv | 35 +++
 rtl/jtag_dbg_bridge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/jtag_dbg_pkg.sv
// Shared opcodes, FSM states and status-word layout for the JTAG debug bridge.
package jtag_dbg_pkg;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SETADDR = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_CLRERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int STAT_BUSY = 31;
  localparam int STAT_OVR  = 30;
  localparam int STAT_TMO  = 29;
  localparam int STAT_RDV  = 28;

  function automatic logic [31:0] mk_status(input logic busy, input logic ovr,
                                            input logic tmo, input logic rdv,
                                            input logic [23:0] addr);
    logic [31:0] s;
    s            = '0;
    s[STAT_BUSY] = busy;
    s[STAT_OVR]  = ovr;
    s[STAT_TMO]  = tmo;
    s[STAT_RDV]  = rdv;
    s[23:0]      = addr;
    return s;
  endfunction

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Loadable saturating down-counter; expired is high while the count is zero.
// load wins over dec; no backpressure, one update per clock.
module dbg_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/jtag_dbg_bridge.sv
// JTAG debug-register strobes -> single-outstanding memory-bus master with readback.
// Request appears one cycle after the strobe; strobes while busy are dropped and flag overrun.
module jtag_dbg_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dbgreg_in,
  input  logic              dbgreg_sel,
  input  logic              dbgreg_strobe,
  output logic [31:0]       dbgreg_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wen,
  output logic              mem_ren,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rd_sel_q, rd_sel_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overrun_q, overrun_d;
  logic              tmo_err_q, tmo_err_d;
  logic              incr_q, incr_d;

  logic [1:0]        op;
  logic              tmo_expired;
  logic [23:0]       addr24;
  logic              unused_in;

  assign op        = dbgreg_in[31:30];
  assign busy      = (state_q != ST_IDLE);
  assign unused_in = ^dbgreg_in;

  dbg_timeout_ctr #(.W(TW)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == ST_IDLE),
    .load_val (TW'(TIMEOUT - 1)),
    .dec      (busy),
    .expired  (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_sel_d   = rd_sel_q;
    rd_valid_d = rd_valid_q;
    overrun_d  = overrun_q;
    tmo_err_d  = tmo_err_q;
    incr_d     = incr_q;

    case (state_q)
      ST_IDLE: begin
        if (dbgreg_strobe) begin
          if (dbgreg_sel) begin
            state_d = ST_WRITE;
            wdata_d = dbgreg_in;
          end else begin
            case (op)
              OP_NOP:     rd_sel_d = dbgreg_in[0];
              OP_SETADDR: addr_d   = {dbgreg_in[ADDR_W-1:2], 2'b00};
              OP_READ: begin
                state_d    = ST_READ;
                incr_d     = dbgreg_in[0];
                rd_valid_d = 1'b0;
              end
              default: begin
                overrun_d  = 1'b0;
                tmo_err_d  = 1'b0;
                rd_valid_d = 1'b0;
              end
            endcase
          end
        end
      end

      ST_WRITE, ST_READ: begin
        // CLRERR is applied first so a same-cycle completion or timeout still records its flag.
        if (dbgreg_strobe) begin
          if (!dbgreg_sel && (op == OP_CLRERR)) begin
            overrun_d  = 1'b0;
            tmo_err_d  = 1'b0;
            rd_valid_d = 1'b0;
          end else begin
            overrun_d = 1'b1;
          end
        end
        if (mem_ready) begin
          state_d = ST_IDLE;
          if (state_q == ST_WRITE) begin
            addr_d = addr_q + ADDR_W'(4);
          end else begin
            rdata_d    = mem_rdata;
            rd_valid_d = 1'b1;
            if (incr_q) addr_d = addr_q + ADDR_W'(4);
          end
        end else if (tmo_expired) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      incr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_sel_q   <= rd_sel_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      tmo_err_q  <= tmo_err_d;
      incr_q     <= incr_d;
    end
  end

  if (ADDR_W >= 24) begin : g_st_wide
    assign addr24 = addr_q[23:0];
  end else begin : g_st_narrow
    assign addr24 = {{(24 - ADDR_W){1'b0}}, addr_q};
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wen    = (state_q == ST_WRITE) ? 4'hF : 4'h0;
  assign mem_ren    = (state_q == ST_READ);
  assign dbgreg_out = rd_sel_q ? rdata_q
                               : mk_status(busy, overrun_q, tmo_err_q, rd_valid_q, addr24);

endmodule
